// File: rtl/core_exec_ctrl.sv
// core_exec_ctrl: execute-stage sequencing controller.
// Single-cycle engines (ALU/CSR/RSV) pass straight through in IDLE.
// MUL has a fixed latency and is counted down locally; DIV is waited on
// via its done pulse. The controller stalls the pipeline until the result
// is ready, and handles flush/abort.
// Optional build macro: CORE_EXEC_CTRL_PERF_EN adds a saturating 32-bit
// stall_cycles counter output.

package core_pkg;
  typedef enum logic [2:0] {
    EXEC_ALU = 3'd0,
    EXEC_MUL = 3'd1,
    EXEC_DIV = 3'd2,
    EXEC_CSR = 3'd3,
    EXEC_RSV = 3'd4
  } exec_engine_e;
endpackage

module core_exec_ctrl #(
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exec_valid,
  input  core_pkg::exec_engine_e exec_engine,
  input  logic                  flush,
  input  logic                  wb_ready,
  input  logic                  div_done,
  output logic                  exec_ready,
  output logic                  result_valid,
  output core_pkg::exec_engine_e sel_engine,
  output logic                  mul_start,
  output logic                  div_start,
  output logic                  div_abort
`ifdef CORE_EXEC_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);
  import core_pkg::*;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MUL_WAIT = 2'd1;
  localparam logic [1:0] S_DIV_WAIT = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  exec_engine_e eng_q, eng_d;
  logic         acc_s;

  // Next-state, register-update and output decode for the sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    eng_d        = eng_q;
    exec_ready   = 1'b0;
    result_valid = 1'b0;
    mul_start    = 1'b0;
    div_start    = 1'b0;
    div_abort    = 1'b0;
    acc_s        = (state_q == S_IDLE) && exec_valid && !flush;
    sel_engine   = (state_q == S_IDLE) ? exec_engine : eng_q;

    case (state_q)
      S_IDLE: begin
        if (acc_s) begin
          case (exec_engine)
            EXEC_MUL: begin
              mul_start = 1'b1;
              eng_d     = EXEC_MUL;
              cnt_d     = MUL_CNT_INIT;
              state_d   = (MUL_LATENCY == 1) ? S_DONE : S_MUL_WAIT;
            end
            EXEC_DIV: begin
              div_start = 1'b1;
              eng_d     = EXEC_DIV;
              state_d   = S_DIV_WAIT;
            end
            default: begin
              // Single-cycle engines (and unknown codes) complete in place.
              result_valid = 1'b1;
              exec_ready   = wb_ready;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL_WAIT;
        end
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DIV_WAIT;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (wb_ready) begin
          exec_ready = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything; an outstanding divide must be aborted
    // even if its done pulse lands in the same cycle. The multiplier is
    // simply left to finish and its result is ignored.
    if (flush) begin
      state_d      = S_IDLE;
      result_valid = 1'b0;
      exec_ready   = 1'b0;
      mul_start    = 1'b0;
      div_start    = 1'b0;
      div_abort    = (state_q == S_DIV_WAIT);
    end else begin
      div_abort = 1'b0;
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      eng_q   <= EXEC_ALU;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eng_q   <= eng_d;
    end
  end

`ifdef CORE_EXEC_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stalled_s;

  // Count cycles in which the pipeline is held by a multi-cycle engine or by writeback.
  always_comb begin
    stalled_s = (state_q == S_MUL_WAIT) || (state_q == S_DIV_WAIT) ||
                ((state_q == S_DONE) && !wb_ready);
    if (stalled_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_core_exec_ctrl.sv
// Self-checking bench for core_exec_ctrl: directed scenarios followed by
// randomized traffic, all checked against a timestamp-based transaction model.
module tb_core_exec_ctrl;
  import core_pkg::*;

  localparam int LAT = 3;
  localparam int NEVER = 32'h7FFF_FFFF;

  logic         clk;
  logic         rst;
  logic         exec_valid;
  exec_engine_e exec_engine;
  logic         flush;
  logic         wb_ready;
  logic         div_done;
  logic         exec_ready;
  logic         result_valid;
  exec_engine_e sel_engine;
  logic         mul_start;
  logic         div_start;
  logic         div_abort;
`ifdef CORE_EXEC_CTRL_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  core_exec_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .exec_valid   (exec_valid),
    .exec_engine  (exec_engine),
    .flush        (flush),
    .wb_ready     (wb_ready),
    .div_done     (div_done),
    .exec_ready   (exec_ready),
    .result_valid (result_valid),
    .sel_engine   (sel_engine),
    .mul_start    (mul_start),
    .div_start    (div_start),
    .div_abort    (div_abort)
`ifdef CORE_EXEC_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction model: an instruction in flight and the cycle its result appears.
  logic         m_busy = 1'b0;
  exec_engine_e m_eng  = EXEC_ALU;
  int           m_avail = NEVER;
  longint       m_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model.
  task automatic step(input logic v, input exec_engine_e eng, input logic fl,
                      input logic wb, input logic dd, input logic r);
    logic e_rv, e_er, e_ms, e_ds, e_da, have;
    exec_engine_e e_sel;
    exec_valid = v; exec_engine = eng; flush = fl;
    wb_ready = wb; div_done = dd; rst = r;
    #4;
    e_rv = 1'b0; e_er = 1'b0; e_ms = 1'b0; e_ds = 1'b0; e_da = 1'b0;
    e_sel = m_busy ? m_eng : eng;
    have = m_busy && (cyc >= m_avail);
    check("result_valid", {31'd0, result_valid}, {31'd0, e_rv | (1'b0)} | 32'd0 |
          {31'd0, (!m_busy && v && !fl && eng != EXEC_MUL && eng != EXEC_DIV) ||
                  (have && !fl)});
    e_rv = (!m_busy && v && !fl && eng != EXEC_MUL && eng != EXEC_DIV) || (have && !fl);
    e_er = e_rv && wb;
    e_ms = !m_busy && v && !fl && eng == EXEC_MUL;
    e_ds = !m_busy && v && !fl && eng == EXEC_DIV;
    e_da = m_busy && fl && m_eng == EXEC_DIV && !have;
    check("exec_ready", {31'd0, exec_ready}, {31'd0, e_er});
    check("mul_start", {31'd0, mul_start}, {31'd0, e_ms});
    check("div_start", {31'd0, div_start}, {31'd0, e_ds});
    check("div_abort", {31'd0, div_abort}, {31'd0, e_da});
    check("sel_engine", {29'd0, sel_engine}, {29'd0, e_sel});
`ifdef CORE_EXEC_CTRL_PERF_EN
    check("stall_cycles", stall_cycles, 32'(m_stall));
`endif
    // Model update for the coming edge.
    if (m_busy && (!have || !wb) && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (r) begin
      m_busy = 1'b0; m_eng = EXEC_ALU; m_avail = NEVER; m_stall = 0;
    end else if (!m_busy) begin
      if (e_ms) begin m_busy = 1'b1; m_eng = EXEC_MUL; m_avail = cyc + LAT; end
      else if (e_ds) begin m_busy = 1'b1; m_eng = EXEC_DIV; m_avail = NEVER; end
    end else if (fl) begin
      m_busy = 1'b0;
    end else if (have) begin
      if (wb) m_busy = 1'b0;
    end else if (m_eng == EXEC_DIV && dd) begin
      m_avail = cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic         r_v, r_fl, r_wb, r_dd, r_rst;
  exec_engine_e r_eng;

  initial begin
    exec_valid = 1'b0; exec_engine = EXEC_ALU; flush = 1'b0;
    wb_ready = 1'b0; div_done = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: idle, all outputs low, sel follows input.
    step(1'b0, EXEC_CSR, 1'b0, 1'b0, 1'b0, 1'b0);
    // ALU / CSR / unlisted pass-through.
    step(1'b1, EXEC_ALU, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, EXEC_CSR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, exec_engine_e'(3'd7), 1'b0, 1'b1, 1'b0, 1'b0);
    // MUL latency.
    repeat (LAT + 1) step(1'b1, EXEC_MUL, 1'b0, 1'b1, 1'b0, 1'b0);
    // DIV with writeback backpressure.
    step(1'b1, EXEC_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (32) step(1'b1, EXEC_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, EXEC_DIV, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, EXEC_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, EXEC_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, EXEC_ALU, 1'b0, 1'b1, 1'b0, 1'b0);
    // DIV abort, without and with a coincident done pulse.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, EXEC_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b1, EXEC_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, EXEC_DIV, 1'b1, 1'b1, k[0], 1'b0);
      step(1'b0, EXEC_ALU, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    // Flush at accept.
    step(1'b1, EXEC_MUL, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, EXEC_ALU, 1'b0, 1'b1, 1'b0, 1'b0);
    // Reset mid-MUL, then a normal DIV.
    step(1'b1, EXEC_MUL, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, EXEC_MUL, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, EXEC_ALU, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, EXEC_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, EXEC_DIV, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, EXEC_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    // Randomized traffic; operands held while an instruction is in flight.
    r_v = 1'b0; r_eng = EXEC_ALU;
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy) begin
        r_v   = ($urandom_range(0, 3) != 0);
        r_eng = exec_engine_e'(3'($urandom_range(0, 7)));
      end
      r_fl  = ($urandom_range(0, 9) == 0);
      r_wb  = ($urandom_range(0, 3) != 0);
      r_dd  = ($urandom_range(0, 5) == 0);
      r_rst = ($urandom_range(0, 63) == 0);
      step(r_v, r_eng, r_fl, r_wb, r_dd, r_rst);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
